// File: rtl/muldiv_unit.sv
// Iterative 32-bit RISC-V M-extension unit: shift-add multiply and restoring divide,
// one radix-2 step per clock, fixed 32-step latency from acceptance to the done pulse.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  wb_addr,
    output logic        wb_we
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_opb;
    logic [63:0] r_acc;
    logic        r_neg;
    logic [4:0]  r_rd;
    logic [31:0] r_result;
    logic [4:0]  r_wb_addr;

    logic        w_accept, w_last, w_is_div, w_sa, w_sb, w_neg_in;
    logic [31:0] w_amag, w_bmag;
    logic [32:0] w_sum, w_shift, w_diff;
    logic [63:0] w_mul_next, w_div_next, w_acc_step, w_prod;
    logic [31:0] w_qr, w_qr_fin, w_fin;

    assign w_accept = start && (r_state != S_CALC);
    assign w_last   = (r_state == S_CALC) && (r_cnt == 5'd31);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Both algorithms run on magnitudes; the sign is restored once at the final step.
    assign w_is_div = funct3[2];
    assign w_sa     = rs1_val[31] & (w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11));
    assign w_sb     = rs2_val[31] & (w_is_div ? ~funct3[0] : ~funct3[1]);
    assign w_amag   = w_sa ? -rs1_val : rs1_val;
    assign w_bmag   = w_sb ? -rs2_val : rs2_val;
    // Divide-by-zero leaves an all-ones quotient magnitude, so its negation is suppressed.
    assign w_neg_in = !w_is_div ? (w_sa ^ w_sb) :
                      funct3[1] ? w_sa : ((w_sa ^ w_sb) & (rs2_val != 32'd0));

    assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_sum, r_acc[31:1]};
    assign w_shift    = {r_acc[63:32], r_acc[31]};
    assign w_diff     = w_shift - {1'b0, r_opb};
    assign w_div_next = w_diff[32] ? {w_shift[31:0], r_acc[30:0], 1'b0}
                                   : {w_diff[31:0],  r_acc[30:0], 1'b1};
    assign w_acc_step = r_op[2] ? w_div_next : w_mul_next;

    assign w_prod   = r_neg ? -w_acc_step : w_acc_step;
    assign w_qr     = r_op[1] ? w_acc_step[63:32] : w_acc_step[31:0];
    assign w_qr_fin = r_neg ? -w_qr : w_qr;
    assign w_fin    = r_op[2] ? w_qr_fin :
                      (r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_result  <= 32'd0;
            r_wb_addr <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= 5'd0;
            else if (r_state == S_CALC)
                r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_result  <= w_fin;
                r_wb_addr <= r_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= funct3;
            r_opb <= w_bmag;
            r_acc <= {32'd0, w_amag};
            r_neg <= w_neg_in;
            r_rd  <= rd_addr;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_step;
        end
    end

    assign busy    = (r_state == S_CALC);
    assign done    = (r_state == S_DONE);
    assign result  = r_result;
    assign wb_addr = r_wb_addr;
    assign wb_we   = done && (r_wb_addr != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases and randomized operations against
// an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        busy, done, wb_we;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
        .busy(busy), .done(done), .result(result), .wb_addr(wb_addr), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb, q;
        sa = a;
        sb = b;
        case (f)
            3'd0: begin sp = longint'(sa) * longint'(sb); return sp[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; return q;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                q = sa % sb; return q;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation and waits (bounded) for its done pulse; lat is -1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] wa,
                          output logic we, output int lat);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; res = 32'd0; wa = 5'd0; we = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n; res = result; wa = wb_addr; we = wb_we;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, wb_we, result, wb_addr} !== 40'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b res=%h wa=%0d, want all 0",
                     busy, done, wb_we, result, wb_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, wb_we, result, wb_addr} !== 40'd0) begin
                n_bad++;
                $display("FAIL idle_cycle%0d: got busy=%b done=%b we=%b res=%h wa=%0d, want all 0",
                         i, busy, done, wb_we, result, wb_addr);
            end
        end
    endtask

    task automatic test_directed();
        logic [2:0]  tf [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] ta [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                 32'hFFFFFFF9, 32'd100, 32'd100, 32'h55, 32'h1234,
                                 32'h80000000, 32'h80000000};
        logic [31:0] tb [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] te [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234,
                                 32'h80000000, 32'd0};
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_op(tf[i], ta[i], tb[i], 5'd5, res, wa, we, lat);
            n_cmp++;
            if (lat !== 32 || res !== te[i] || wa !== 5'd5 || we !== 1'b1) begin
                n_bad++;
                $display("FAIL directed%0d f=%0d: got lat=%0d res=%h wa=%0d we=%b, want lat=32 res=%h wa=5 we=1",
                         i, tf[i], lat, res, wa, we, te[i]);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || wb_we !== 1'b0 || result !== te[i]) begin
                n_bad++;
                $display("FAIL directed%0d_after: got done=%b we=%b res=%h, want done=0 we=0 res=%h",
                         i, done, wb_we, result, te[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        logic [4:0]  rd, wa;
        logic        we;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            rd = 5'($urandom_range(0, 31));
            exp = model(f, a, b);
            run_op(f, a, b, rd, res, wa, we, lat);
            n_cmp++;
            if (lat !== 32 || res !== exp || wa !== rd || we !== (rd != 5'd0)) begin
                n_bad++;
                $display("FAIL random%0d f=%0d a=%h b=%h: got lat=%0d res=%h wa=%0d we=%b, want lat=32 res=%h wa=%0d we=%b",
                         i, f, a, b, lat, res, wa, we, exp, rd, rd != 5'd0);
            end
        end
    endtask

    task automatic test_rd0_ignore();
        int n_done = -1;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 5) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_in_calc: got %b want 1", busy);
                end
            end
            if (n == 10) begin
                start = 1'b1; funct3 = 3'd1; rs1_val = 32'hFFFFFFFF; rs2_val = 32'hFFFFFFFF; rd_addr = 5'd9;
            end
            if (n == 11) start = 1'b0;
            if (done) begin
                n_done = n;
                break;
            end
        end
        n_cmp++;
        if (n_done !== 32 || result !== 32'd12 || wb_we !== 1'b0 || wb_addr !== 5'd0) begin
            n_bad++;
            $display("FAIL rd0_ignore: got lat=%0d res=%h we=%b wa=%0d, want lat=32 res=0000000c we=0 wa=0",
                     n_done, result, wb_we, wb_addr);
        end
    endtask

    task automatic test_reset_midcalc();
        int seen = 0;
        logic [31:0] res, exp;
        logic [4:0]  wa;
        logic        we;
        int          lat;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3; rd_addr = 5'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, wb_we, result, wb_addr} !== 40'd0) begin
            n_bad++;
            $display("FAIL midcalc_reset: got busy=%b done=%b we=%b res=%h wa=%0d, want all 0",
                     busy, done, wb_we, result, wb_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || wb_we || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL aborted_op: got %0d active cycles after release, want 0", seen);
        end
        exp = model(3'd6, 32'hFFFFFF00, 32'd7);
        run_op(3'd6, 32'hFFFFFF00, 32'd7, 5'd3, res, wa, we, lat);
        n_cmp++;
        if (lat !== 32 || res !== exp || wa !== 5'd3 || we !== 1'b1) begin
            n_bad++;
            $display("FAIL first_after_reset: got lat=%0d res=%h wa=%0d we=%b, want lat=32 res=%h wa=3 we=1",
                     lat, res, wa, we, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, exp1, exp2;
        logic [4:0]  wa;
        logic        we;
        int          lat;
        int          gap = -1;
        exp1 = model(3'd1, 32'h12345678, 32'hFEDCBA98);
        exp2 = model(3'd4, 32'hFFFF0000, 32'd9);
        run_op(3'd1, 32'h12345678, 32'hFEDCBA98, 5'd11, res, wa, we, lat);
        start = 1'b1; funct3 = 3'd4; rs1_val = 32'hFFFF0000; rs2_val = 32'd9; rd_addr = 5'd12;
        #1;
        n_cmp++;
        if (lat !== 32 || done !== 1'b1 || wb_we !== 1'b1 || result !== exp1 || wb_addr !== 5'd11) begin
            n_bad++;
            $display("FAIL b2b_first: got lat=%0d done=%b we=%b res=%h wa=%0d, want lat=32 done=1 we=1 res=%h wa=11",
                     lat, done, wb_we, result, wb_addr, exp1);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                gap = n + 1;
                break;
            end
        end
        n_cmp++;
        if (gap !== 33 || result !== exp2 || wb_we !== 1'b1 || wb_addr !== 5'd12) begin
            n_bad++;
            $display("FAIL b2b_second: got gap=%0d res=%h we=%b wa=%0d, want gap=33 res=%h we=1 wa=12",
                     gap, result, wb_we, wb_addr, exp2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rd0_ignore();
        test_random();
        test_reset_midcalc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 funct3  input  3  operation code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_val  input  32  operand A / dividend, driven from register-file read port 1.
REQ-007 rs2_val  input  32  operand B / divisor, driven from register-file read port 2.
REQ-008 rd_addr  input  5  destination register index.
REQ-009 busy  output  1  high while an operation is iterating.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  32  final 32-bit result.
REQ-012 wb_addr  output  5  destination index, feeds register-file write address.
REQ-013 wb_we  output  1  register-file write enable.

Function
REQ-014 States are IDLE, CALC and DONE; busy = (state == CALC); done = (state == DONE).
REQ-015 Acceptance: start=1 on a rising edge while busy=0 (IDLE or DONE) captures funct3, rs1_val, rs2_val and rd_addr, clears the step counter, and moves to CALC.
REQ-016 start while busy=1 is ignored; captured operands and the operation are unaffected.
REQ-017 CALC performs exactly one radix-2 step per edge (shift-add multiply, restoring divide) for 32 edges; the 32nd step edge moves to DONE.
REQ-018 Latency: fixed at 32 edges, independent of operand values and special cases; done is high in the cycle after the 32nd edge following the acceptance edge.
REQ-019 DONE lasts one cycle and then goes to IDLE, or to CALC if start is accepted on that edge.
REQ-020 wb_we = done AND (captured rd_addr != 0); x0 is never written.
REQ-021 result and wb_addr hold their values from DONE until the next acceptance; wb_we is high only in DONE.
REQ-022 MUL returns the low 32 bits of the product; MULH returns the high 32 bits (signed x signed), MULHSU the high 32 bits (signed rs1 x unsigned rs2), and MULHU the high 32 bits (unsigned x unsigned).
REQ-023 DIV/REM: quotient truncates toward zero; remainder takes the sign of the dividend; DIVU/REMU operate unsigned.
REQ-024 Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return rs1_val.
REQ-025 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
REQ-026 Acceptance in DONE: the completing operation's done and wb_we pulse is delivered unchanged in that cycle; the new operation's result appears 32 edges later.

Reset
REQ-027 rst_n=0 forces, without waiting for clk: state IDLE, busy=0, done=0, wb_we=0, result=0, wb_addr=0, counter=0.
REQ-028 A reset asserted mid-CALC aborts the operation; no done or wb_we is produced for it after release.
REQ-029 The first start after rst_n returns high is accepted normally.

Verification
REQ-030 Reset then idle: all outputs 0, busy=0 for 5 cycles with start=0.
REQ-031 MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> done high in the cycle after the 32nd edge, result=0xFFFFFFEB, wb_addr=5, wb_we=1 for exactly one cycle; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-033 DIV x / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; all with standard latency.
REQ-034 rd_addr=0 MUL 3 x 4 -> done pulses, result=12, wb_we stays 0; start with changed operands pulsed at cycle 10 of CALC -> ignored, result unchanged.
REQ-035 rst_n low at step 16 -> all outputs 0 immediately, no done after release; back-to-back start in DONE -> two done pulses 33 cycles apart with correct results.
